// File: rtl/softmax_max_sub_pkg.sv
// Shared types, constants and arithmetic helpers for the softmax max-subtract stage.
package softmax_pkg;

   localparam int LANES = 8;
   localparam int DW    = 32;
   localparam int SEGS  = 4;

   typedef enum logic [1:0] {
      SEG_1X8 = 2'd0,
      SEG_2X4 = 2'd1,
      SEG_4X2 = 2'd2
   } seg_mode_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN
   } state_e;

   typedef logic signed [DW-1:0] lane_t;
   typedef lane_t [LANES-1:0]    lane_vec_t;
   typedef lane_t [SEGS-1:0]     seg_max_t;

   localparam lane_t SMIN = {1'b1, {(DW-1){1'b0}}};

   function automatic lane_t smax(lane_t a, lane_t b);
      return (a > b) ? a : b;
   endfunction

   // The reserved encoding falls back to a single segment.
   function automatic seg_mode_e decode_mode(logic [1:0] m);
      return (m == 2'd3) ? SEG_1X8 : seg_mode_e'(m);
   endfunction

   function automatic logic [1:0] seg_of(seg_mode_e m, int lane);
      case (m)
         SEG_2X4: return 2'(lane / 4);
         SEG_4X2: return 2'(lane / 2);
         default: return 2'd0;
      endcase
   endfunction

   // a - b at DW+1 bits; underflow clamps to the most-negative value.
   function automatic lane_t sat_sub(lane_t a, lane_t b);
      logic signed [DW:0] d;
      d = {a[DW-1], a} - {b[DW-1], b};
      if (d > 0)
         return '0;
      else if (d[DW] != d[DW-1])
         return SMIN;
      else
         return lane_t'(d[DW-1:0]);
   endfunction

endpackage

// File: rtl/softmax_max_sub_if.sv
// Input/output stream bundle of the max-subtract stage.
interface softmax_max_sub_if;
   import softmax_pkg::*;

   logic [1:0] seg_mode;
   logic       in_valid;
   logic       in_ready;
   lane_vec_t  in_data;
   logic       out_valid;
   logic       out_ready;
   lane_vec_t  out_data;
   seg_max_t   out_max;
   logic       out_last;

   modport master (
      output seg_mode, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_max, out_last
   );

   modport slave (
      input  seg_mode, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_max, out_last
   );

endinterface

// File: rtl/softmax_max_sub_seg_beat_max.sv
// Per-beat segment maxima: a 3-level pairwise compare tree, with the 2- and 4-lane levels tapped.
module seg_beat_max
   import softmax_pkg::*;
(
   input  lane_vec_t lanes_i,
   input  seg_mode_e mode_i,
   output seg_max_t  seg_max_o
);

   lane_t l1 [4];
   lane_t l2 [2];
   lane_t l3;

   always_comb begin
      for (int j = 0; j < 4; j++) l1[j] = smax(lanes_i[2*j], lanes_i[2*j+1]);
      for (int j = 0; j < 2; j++) l2[j] = smax(l1[2*j], l1[2*j+1]);
      l3 = smax(l2[0], l2[1]);

      // NOTE: every output gets a default before the case so no latch is inferred.
      seg_max_o = {SEGS{SMIN}};
      case (mode_i)
         SEG_4X2: for (int j = 0; j < 4; j++) seg_max_o[j] = l1[j];
         SEG_2X4: begin
            seg_max_o[0] = l2[0];
            seg_max_o[1] = l2[1];
         end
         default: seg_max_o[0] = l3;
      endcase
   end

endmodule

// File: rtl/softmax_max_sub.sv
// Buffers one score row while tracking segment maxima, then replays it as lane - segmax.
module softmax_max_sub
   import softmax_pkg::*;
#(
   parameter int ROW_BEATS = 4
) (
   input logic              clk,
   input logic              rst_n,
   softmax_max_sub_if.slave bus
);

   localparam int             CW        = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
   localparam logic [CW-1:0]  LAST_BEAT = CW'(ROW_BEATS - 1);

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   seg_mode_e      mode_q, mode_d;
   seg_max_t       segmax_q, segmax_d;
   lane_vec_t      out_data_q, out_data_d;
   seg_max_t       out_max_q, out_max_d;
   lane_vec_t      buf_q [ROW_BEATS];

   seg_max_t       beat_max;
   seg_mode_e      mode_eff;
   logic           first_beat;
   logic           in_fire;

   assign first_beat = (state_q == S_IDLE);
   assign in_fire    = bus.in_valid && bus.in_ready;
   assign mode_eff   = first_beat ? decode_mode(bus.seg_mode) : mode_q;

   seg_beat_max u_beat_max (
      .lanes_i   (bus.in_data),
      .mode_i    (mode_eff),
      .seg_max_o (beat_max)
   );

   function automatic lane_vec_t reduce_beat(lane_vec_t beat, seg_max_t mx, seg_mode_e m);
      lane_vec_t r;
      for (int i = 0; i < LANES; i++) r[i] = sat_sub(beat[i], mx[seg_of(m, i)]);
      return r;
   endfunction

   // Unused segments hold SMIN internally but are presented as zero.
   function automatic seg_max_t mask_max(seg_max_t mx, seg_mode_e m);
      seg_max_t r;
      r = '0;
      case (m)
         SEG_4X2: r = mx;
         SEG_2X4: begin
            r[0] = mx[0];
            r[1] = mx[1];
         end
         default: r[0] = mx[0];
      endcase
      return r;
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mode_d     = mode_q;
      segmax_d   = segmax_q;
      out_data_d = out_data_q;
      out_max_d  = out_max_q;

      case (state_q)
         S_IDLE, S_LOAD: begin
            if (in_fire) begin
               mode_d = mode_eff;
               for (int k = 0; k < SEGS; k++)
                  segmax_d[k] = first_beat ? beat_max[k] : smax(segmax_q[k], beat_max[k]);
               if (cnt_q == LAST_BEAT) begin
                  // First drain beat is prepared here so it is valid right after the last load.
                  state_d    = S_DRAIN;
                  cnt_d      = '0;
                  out_max_d  = mask_max(segmax_d, mode_d);
                  out_data_d = reduce_beat((ROW_BEATS == 1) ? bus.in_data : buf_q[0],
                                           segmax_d, mode_d);
               end else begin
                  state_d = S_LOAD;
                  cnt_d   = cnt_q + CW'(1);
               end
            end
         end
         S_DRAIN: begin
            if (bus.out_ready) begin
               if (cnt_q == LAST_BEAT) begin
                  state_d    = S_IDLE;
                  cnt_d      = '0;
                  segmax_d   = {SEGS{SMIN}};
                  out_data_d = '0;
                  out_max_d  = '0;
               end else begin
                  cnt_d      = cnt_q + CW'(1);
                  out_data_d = reduce_beat(buf_q[cnt_q + CW'(1)], segmax_q, mode_q);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         mode_q     <= SEG_1X8;
         segmax_q   <= {SEGS{SMIN}};
         out_data_q <= '0;
         out_max_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         segmax_q   <= segmax_d;
         out_data_q <= out_data_d;
         out_max_q  <= out_max_d;
      end
   end

   // NOTE: the row buffer is not reset; every entry is written before it is read.
   always_ff @(posedge clk) begin
      if (in_fire) buf_q[cnt_q] <= bus.in_data;
   end

   assign bus.in_ready  = (state_q != S_DRAIN);
   assign bus.out_valid = (state_q == S_DRAIN);
   assign bus.out_last  = (state_q == S_DRAIN) && (cnt_q == LAST_BEAT);
   assign bus.out_data  = out_data_q;
   assign bus.out_max   = out_max_q;

endmodule

// File: tb/tb_softmax_max_sub.sv
// Table-driven bench for softmax_max_sub with a queue scoreboard and reset/backpressure sequences.
module tb_softmax_max_sub;
   import softmax_pkg::*;

   typedef struct {
      logic [1:0] mode;
      lane_vec_t  beats [4];
      seg_max_t   exp_max;
      logic [7:0] pat;
   } vec_t;

   typedef struct {
      lane_vec_t data;
      logic      last;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   deliv;
   exp_t sb [$];
   lane_vec_t got_row [4];
   logic [3:0] got_last;
   logic       held;
   lane_vec_t  held_data;
   seg_max_t   held_max;
   logic       held_last;
   vec_t       tbl [6];

   softmax_max_sub_if bus ();

   softmax_max_sub #(.ROW_BEATS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_lane(input string name, input lane_t act, input int exp);
      check(name, {224'd0, act}, {224'd0, 32'(exp)});
   endtask

   function automatic lane_vec_t ramp(int base, int step, int b);
      lane_vec_t r;
      for (int i = 0; i < LANES; i++) r[i] = lane_t'(base + step * (b * 8 + i));
      return r;
   endfunction

   function automatic lane_vec_t mk8(int a0, int a1, int a2, int a3, int a4, int a5, int a6, int a7);
      lane_vec_t r;
      r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
      r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
      return r;
   endfunction

   function automatic seg_max_t mk_max(int m0, int m1, int m2, int m3);
      seg_max_t r;
      r[0] = m0; r[1] = m1; r[2] = m2; r[3] = m3;
      return r;
   endfunction

   function automatic int model_seg(logic [1:0] mode, int lane);
      if (mode == 2'd1) return lane / 4;
      if (mode == 2'd2) return lane / 2;
      return 0;
   endfunction

   // Output monitor: scoreboard compare, hold-under-backpressure and in_ready checks.
   always @(negedge clk) begin
      if (!rst_n) begin
         held = 1'b0;
      end else if (bus.out_valid) begin
         check("in_ready_in_drain", {255'd0, bus.in_ready}, 256'd0);
         if (held) begin
            check("hold_data", bus.out_data, held_data);
            check("hold_max", bus.out_max, held_max);
            check("hold_last", {255'd0, bus.out_last}, {255'd0, held_last});
         end
         if (bus.out_ready) begin
            held = 1'b0;
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underflow: got extra beat %h expected none", bus.out_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("out_data", bus.out_data, e.data);
               check("out_last", {255'd0, bus.out_last}, {255'd0, e.last});
            end
            if (deliv < 4) begin
               got_row[deliv]  = bus.out_data;
               got_last[deliv] = bus.out_last;
            end
            deliv++;
         end else begin
            held      = 1'b1;
            held_data = bus.out_data;
            held_max  = bus.out_max;
            held_last = bus.out_last;
         end
      end else begin
         held = 1'b0;
      end
   end

   task automatic run_row(input vec_t v);
      longint mx [4];
      longint x;
      longint d;
      exp_t   e;
      logic   acc;
      for (int k = 0; k < 4; k++) mx[k] = -64'sd2147483648;
      for (int b = 0; b < 4; b++)
         for (int i = 0; i < LANES; i++) begin
            x = longint'(v.beats[b][i]);
            if (x > mx[model_seg(v.mode, i)]) mx[model_seg(v.mode, i)] = x;
         end
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < LANES; i++) begin
            d = longint'(v.beats[b][i]) - mx[model_seg(v.mode, i)];
            if (d < -64'sd2147483648) d = -64'sd2147483648;
            e.data[i] = lane_t'(d);
         end
         e.last = (b == 3);
         sb.push_back(e);
      end
      deliv    = 0;
      got_last = '0;

      @(posedge clk); #1;
      for (int b = 0; b < 4; b++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = v.beats[b];
         bus.seg_mode = (b == 0) ? v.mode : v.mode + 2'd1;
         acc = 1'b0;
         for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            if (b == 3 && t == 0) check("no_early_out_valid", {255'd0, bus.out_valid}, 256'd0);
            acc = bus.in_ready;
            @(posedge clk); #1;
         end
         if (!acc) check("in_accept_timeout", 256'd0, 256'd1);
      end

      // Keep offering junk during drain; it must be ignored.
      bus.in_data   = '1;
      bus.out_ready = v.pat[0];
      @(negedge clk);
      check("latency_out_valid", {255'd0, bus.out_valid}, 256'd1);
      check("out_max", bus.out_max, v.exp_max);
      for (int c = 1; c < 40 && deliv < 4; c++) begin
         @(posedge clk); #1;
         bus.out_ready = (c < 8) ? v.pat[c] : 1'b1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("beats_delivered", 256'(deliv), 256'd4);
      check("sb_drained", 256'(sb.size()), 256'd0);
      @(negedge clk);
      check("out_valid_after_row", {255'd0, bus.out_valid}, 256'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      deliv    = 0;
      held     = 1'b0;

      for (int b = 0; b < 4; b++) begin
         tbl[0].beats[b] = ramp(0, 1, b);
         tbl[1].beats[b] = (b == 1) ? mk8(5, -3, 7, 7, -100, -200, 0, 1) : {LANES{lane_t'(-1000)}};
         tbl[2].beats[b] = (b == 0) ? mk8(32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 0, 0, 0, 0) : '0;
         tbl[3].beats[b] = ramp(100, -1, b);
         tbl[4].beats[b] = ramp(-5, -1, b);
         tbl[5].beats[b] = ramp(10, 1, b);
      end
      tbl[0].mode = 2'd0; tbl[0].exp_max = mk_max(31, 0, 0, 0);           tbl[0].pat = 8'hFF;
      tbl[1].mode = 2'd2; tbl[1].exp_max = mk_max(5, 7, -100, 1);         tbl[1].pat = 8'hFF;
      tbl[2].mode = 2'd0; tbl[2].exp_max = mk_max(32'h7FFF_FFFF, 0, 0, 0); tbl[2].pat = 8'hFF;
      tbl[3].mode = 2'd1; tbl[3].exp_max = mk_max(100, 96, 0, 0);         tbl[3].pat = 8'b1111_1001;
      tbl[4].mode = 2'd0; tbl[4].exp_max = mk_max(-5, 0, 0, 0);           tbl[4].pat = 8'hFF;
      tbl[5].mode = 2'd1; tbl[5].exp_max = mk_max(37, 41, 0, 0);          tbl[5].pat = 8'hFF;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.seg_mode  = 2'd0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("rst_in_ready", {255'd0, bus.in_ready}, 256'd1);
      check("rst_out_valid", {255'd0, bus.out_valid}, 256'd0);
      check("rst_out_last", {255'd0, bus.out_last}, 256'd0);
      check("rst_out_data", bus.out_data, 256'd0);
      check("rst_out_max", bus.out_max, 256'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int t = 0; t < 6; t++) begin
         run_row(tbl[t]);
         case (t)
            0: begin
               check_lane("asc_b0_l0", got_row[0][0], -31);
               check_lane("asc_b0_l7", got_row[0][7], -24);
               check_lane("asc_b3_l0", got_row[3][0], -7);
               check_lane("asc_b3_l7", got_row[3][7], 0);
               check("asc_last_b3", {255'd0, got_last[3]}, 256'd1);
               check("asc_last_b0", {255'd0, got_last[0]}, 256'd0);
            end
            1: check("seg4_beat1", got_row[1], mk8(0, -8, 0, 0, 0, -100, -1, 0));
            2: check_lane("sat_lane1", got_row[0][1], 32'h8000_0000);
            default: ;
         endcase
      end

      // Reset in the middle of a row; the partial beats must leave no trace.
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = {LANES{lane_t'(5000)}};
      bus.seg_mode = 2'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", {255'd0, bus.out_valid}, 256'd0);
      check("midrst_in_ready", {255'd0, bus.in_ready}, 256'd1);
      check("midrst_out_max", bus.out_max, 256'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      begin
         vec_t fresh;
         fresh.mode = 2'd2;
         for (int b = 0; b < 4; b++) fresh.beats[b] = ramp(0, 1, b);
         fresh.exp_max = mk_max(25, 27, 29, 31);
         fresh.pat     = 8'hFF;
         run_row(fresh);
         check_lane("fresh_b0_l0", got_row[0][0], -25);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
